// File: rtl/util_pack.sv
// Shared constants, route-word type and sequencer state encoding for the Benes route sequencer.
package util_pack;

  localparam int DEF_PORT_NUM   = 32;
  localparam int DEF_SWITCH_NUM = DEF_PORT_NUM / 2;
  localparam int DEF_STAGE_NUM  = 2 * $clog2(DEF_PORT_NUM) - 1;
  localparam int DEF_CFG_DEPTH  = 16;
  localparam int DEF_CNT_W      = 8;
  localparam int DEF_NET_LAT    = 12;

  typedef logic [0:DEF_STAGE_NUM-1][0:DEF_SWITCH_NUM-1] benes_sel_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    RUN   = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } seq_state_t;

endpackage

// File: rtl/benes_cfg_table.sv
// Route table: one write port, registered read, per-entry valid bit.
// Optional even-parity storage and check when BENES_SEQ_PARITY_EN is defined.
module benes_cfg_table #(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int W     = 144
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [W-1:0]  wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [W-1:0]  rd_data,
  output logic          rd_hit,
  output logic          rd_perr
);

  logic [W-1:0]     mem [DEPTH];
  logic [DEPTH-1:0] vld;
  logic             bypass;
  logic [W-1:0]     word;

  // A write landing on the entry being read wins, so the read sees the new route.
  assign bypass = wr_en && (wr_addr == rd_addr);
  assign word   = bypass ? wr_data : mem[rd_addr];
  assign rd_hit = bypass || vld[rd_addr];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst)        vld <= '0;
    else if (wr_en) vld[wr_addr] <= 1'b1;
  end

  // Unwritten entries read as the straight-through route.
  always_ff @(posedge clk) begin
    if (rst)        rd_data <= '0;
    else if (rd_en) rd_data <= rd_hit ? word : '0;
  end

`ifdef BENES_SEQ_PARITY_EN
  logic par_mem [DEPTH];
  logic par;

  always_ff @(posedge clk) begin
    if (wr_en) par_mem[wr_addr] <= ^wr_data;
  end

  assign par     = bypass ? ^wr_data : par_mem[rd_addr];
  assign rd_perr = rd_hit && ((^word) != par);
`else
  assign rd_perr = 1'b0;
`endif

endmodule

// File: rtl/benes_route_sequencer.sv
// Drives held switch-select words for both Benes networks, strobes beats, then drains the pipeline.
// Build option: BENES_SEQ_PARITY_EN enables route-table parity and the sticky o_cfg_err flag.
//
// state | meaning
// IDLE  | waiting for a command, cmd_ready high
// LOAD  | registered read of both route tables
// RUN   | one o_beat per cycle, cmd_count cycles
// DRAIN | net_lat cycles for the network pipeline to empty
// DONE  | one-cycle o_done pulse
module benes_route_sequencer
  import util_pack::*;
#(
  parameter int PORT_NUM   = DEF_PORT_NUM,
  parameter int CFG_DEPTH  = DEF_CFG_DEPTH,
  parameter int CNT_W      = DEF_CNT_W,
  parameter int NET_LAT    = DEF_NET_LAT,
  localparam int SWITCH_NUM = PORT_NUM / 2,
  localparam int STAGE_NUM  = 2 * $clog2(PORT_NUM) - 1,
  localparam int SEL_W      = STAGE_NUM * SWITCH_NUM,
  localparam int CFG_AW     = $clog2(CFG_DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_wr_valid,
  output logic              cfg_wr_ready,
  input  logic              cfg_wr_dir,
  input  logic [CFG_AW-1:0] cfg_wr_addr,
  input  logic [SEL_W-1:0]  cfg_wr_sel,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [CFG_AW-1:0] cmd_mod_idx,
  input  logic [CFG_AW-1:0] cmd_slot_idx,
  input  logic [CNT_W-1:0]  cmd_count,
  output logic [SEL_W-1:0]  o_module_select,
  output logic [SEL_W-1:0]  o_slot_select,
  output logic              o_beat,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_miss,
  output logic              o_cfg_err
);

  localparam int DW = $clog2(NET_LAT + 1);

  seq_state_t        state, state_d;
  logic [CNT_W-1:0]  beat_cnt;
  logic [DW-1:0]     drain_cnt;
  logic [CFG_AW-1:0] mod_idx, slot_idx;
  logic              miss_pend;
  logic              mod_hit, slot_hit, mod_perr, slot_perr;
  logic              rd_en;

  assign cfg_wr_ready = 1'b1;
  assign rd_en        = (state == LOAD);
  assign o_busy       = (state != IDLE);

  benes_cfg_table #(.DEPTH(CFG_DEPTH), .AW(CFG_AW), .W(SEL_W)) u_mod_table (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (cfg_wr_valid && !cfg_wr_dir),
    .wr_addr (cfg_wr_addr),
    .wr_data (cfg_wr_sel),
    .rd_en   (rd_en),
    .rd_addr (mod_idx),
    .rd_data (o_module_select),
    .rd_hit  (mod_hit),
    .rd_perr (mod_perr)
  );

  benes_cfg_table #(.DEPTH(CFG_DEPTH), .AW(CFG_AW), .W(SEL_W)) u_slot_table (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (cfg_wr_valid && cfg_wr_dir),
    .wr_addr (cfg_wr_addr),
    .wr_data (cfg_wr_sel),
    .rd_en   (rd_en),
    .rd_addr (slot_idx),
    .rd_data (o_slot_select),
    .rd_hit  (slot_hit),
    .rd_perr (slot_perr)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d   = state;
    cmd_ready = 1'b0;
    o_beat    = 1'b0;
    o_done    = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_d = LOAD;
      end
      LOAD:  state_d = (beat_cnt == '0) ? DRAIN : RUN;
      RUN: begin
        o_beat = 1'b1;
        if (beat_cnt == CNT_W'(1)) state_d = DRAIN;
      end
      DRAIN: if (drain_cnt == DW'(1)) state_d = DONE;
      DONE: begin
        o_done  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      beat_cnt  <= '0;
      drain_cnt <= '0;
      mod_idx   <= '0;
      slot_idx  <= '0;
      o_miss    <= 1'b0;
      miss_pend <= 1'b0;
      o_cfg_err <= 1'b0;
    end else begin
      o_miss    <= miss_pend;
      miss_pend <= 1'b0;
      if (state == IDLE && cmd_valid) begin
        mod_idx  <= cmd_mod_idx;
        slot_idx <= cmd_slot_idx;
        beat_cnt <= cmd_count;
      end
      if (state == RUN) beat_cnt <= beat_cnt - 1'b1;
      if (state == DRAIN) drain_cnt <= drain_cnt - 1'b1;
      else                drain_cnt <= DW'(NET_LAT);
      // Both directions missing gives two pulses on consecutive cycles.
      if (state == LOAD) begin
        o_miss    <= !mod_hit || !slot_hit;
        miss_pend <= !mod_hit && !slot_hit;
        o_cfg_err <= o_cfg_err | mod_perr | slot_perr;
      end
    end
  end

endmodule

// File: tb/tb_benes_route_sequencer.sv
// Scoreboard bench for benes_route_sequencer; parity checks run when BENES_SEQ_PARITY_EN is defined.
module tb_benes_route_sequencer;
  import util_pack::*;

  localparam int SEL_W = DEF_STAGE_NUM * DEF_SWITCH_NUM;
  localparam int LAT   = DEF_NET_LAT;

  logic             clk = 1'b0;
  logic             rst;
  logic             cfg_wr_valid, cfg_wr_ready, cfg_wr_dir;
  logic [3:0]       cfg_wr_addr;
  logic [SEL_W-1:0] cfg_wr_sel;
  logic             cmd_valid, cmd_ready;
  logic [3:0]       cmd_mod_idx, cmd_slot_idx;
  logic [7:0]       cmd_count;
  logic [SEL_W-1:0] o_module_select, o_slot_select;
  logic             o_beat, o_busy, o_done, o_miss, o_cfg_err;

  typedef struct {
    logic [SEL_W-1:0] mod_sel;
    logic [SEL_W-1:0] slot_sel;
    int               count;
    int               miss;
    logic             err;
  } exp_t;

  exp_t             sb[$];
  logic [SEL_W-1:0] mod_ref [16];
  logic [SEL_W-1:0] slot_ref[16];
  bit               mod_vld [16];
  bit               slot_vld[16];
  logic             err_model;
  int               n_vec = 0;
  int               n_err = 0;

  always #5 clk = ~clk;

  benes_route_sequencer dut (
    .clk             (clk),
    .rst             (rst),
    .cfg_wr_valid    (cfg_wr_valid),
    .cfg_wr_ready    (cfg_wr_ready),
    .cfg_wr_dir      (cfg_wr_dir),
    .cfg_wr_addr     (cfg_wr_addr),
    .cfg_wr_sel      (cfg_wr_sel),
    .cmd_valid       (cmd_valid),
    .cmd_ready       (cmd_ready),
    .cmd_mod_idx     (cmd_mod_idx),
    .cmd_slot_idx    (cmd_slot_idx),
    .cmd_count       (cmd_count),
    .o_module_select (o_module_select),
    .o_slot_select   (o_slot_select),
    .o_beat          (o_beat),
    .o_busy          (o_busy),
    .o_done          (o_done),
    .o_miss          (o_miss),
    .o_cfg_err       (o_cfg_err)
  );

  task automatic chk(input string tag, input logic [SEL_W-1:0] got, input logic [SEL_W-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [SEL_W-1:0] rand_sel();
    logic [159:0] t;
    t = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    return t[SEL_W-1:0];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 16; i++) begin
      mod_vld[i]  = 1'b0;
      slot_vld[i] = 1'b0;
    end
    err_model = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_cfg_ready"}, cfg_wr_ready, 1);
    chk({tag, "_cmd_ready"}, cmd_ready, 1);
    chk({tag, "_mod_sel"}, o_module_select, 0);
    chk({tag, "_slot_sel"}, o_slot_select, 0);
    chk({tag, "_beat"}, o_beat, 0);
    chk({tag, "_busy"}, o_busy, 0);
    chk({tag, "_done"}, o_done, 0);
    chk({tag, "_miss"}, o_miss, 0);
    chk({tag, "_cfg_err"}, o_cfg_err, 0);
  endtask

  task automatic wr(input bit d, input int a, input logic [SEL_W-1:0] v);
    @(negedge clk);
    cfg_wr_valid = 1'b1;
    cfg_wr_dir   = d;
    cfg_wr_addr  = a[3:0];
    cfg_wr_sel   = v;
    if (!d) begin mod_ref[a] = v;  mod_vld[a] = 1'b1;  end
    else    begin slot_ref[a] = v; slot_vld[a] = 1'b1; end
    @(negedge clk);
    cfg_wr_valid = 1'b0;
  endtask

  // rst_at > 0 asserts reset after observing that cycle; the transfer is then expected to abort.
  task automatic run_cmd(input int m, input int s, input int cnt, input bit wr_same,
                         input logic [SEL_W-1:0] wv, input bit rewrite, input int rst_at);
    exp_t e;
    int   cyc, beats, first, misses, done_cyc, dcount;
    @(negedge clk);
    chk("cmd_ready_idle", cmd_ready, 1);
    if (wr_same) begin
      cfg_wr_valid = 1'b1; cfg_wr_dir = 1'b0; cfg_wr_addr = m[3:0]; cfg_wr_sel = wv;
      mod_ref[m] = wv; mod_vld[m] = 1'b1;
    end
    cmd_valid = 1'b1; cmd_mod_idx = m[3:0]; cmd_slot_idx = s[3:0]; cmd_count = cnt[7:0];
    e.mod_sel  = mod_vld[m]  ? mod_ref[m]  : '0;
    e.slot_sel = slot_vld[s] ? slot_ref[s] : '0;
    e.count    = cnt;
    e.miss     = (mod_vld[m] ? 0 : 1) + (slot_vld[s] ? 0 : 1);
    e.err      = err_model;
    sb.push_back(e);
    @(negedge clk);
    cmd_valid = 1'b0; cfg_wr_valid = 1'b0;
    cyc = 1; beats = 0; first = 0; misses = 0; done_cyc = 0;
    chk("busy_in_load", o_busy, 1);
    chk("cmd_ready_busy", cmd_ready, 0);
    while (done_cyc == 0 && cyc <= 300) begin
      if (o_beat) begin beats++; if (first == 0) first = cyc; end
      if (o_miss) misses++;
      if (o_done) done_cyc = cyc;
      if (rst_at != 0 && cyc == rst_at) begin
        chk("beat_before_rst", o_beat, 1);
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("rst_mid_run");
        rst = 1'b0;
        model_clear();
        dcount = 0;
        for (int i = 0; i < 40; i++) begin
          @(negedge clk);
          if (o_done) dcount++;
        end
        chk("no_done_after_rst", dcount, 0);
        void'(sb.pop_front());
        return;
      end
      if (rewrite && cyc == 3) begin
        cfg_wr_valid = 1'b1; cfg_wr_dir = 1'b0; cfg_wr_addr = m[3:0];
        cfg_wr_sel = ~e.mod_sel; mod_ref[m] = ~e.mod_sel; mod_vld[m] = 1'b1;
      end
      if (rewrite && cyc == 4) cfg_wr_valid = 1'b0;
      if (done_cyc == 0) begin
        @(negedge clk);
        cyc++;
      end
    end
    if (done_cyc == 0) begin
      chk("done_timeout", 0, 1);
      void'(sb.pop_front());
      return;
    end
    e = sb.pop_front();
    chk("beat_count", beats, e.count);
    if (e.count > 0) chk("first_beat_cyc", first, 2);
    chk("done_cyc", done_cyc, e.count + LAT + 2);
    chk("module_select", o_module_select, e.mod_sel);
    chk("slot_select", o_slot_select, e.slot_sel);
    chk("miss_pulses", misses, e.miss);
    chk("cfg_err", o_cfg_err, e.err);
    @(negedge clk);
    chk("done_one_cycle", o_done, 0);
    chk("idle_after_done", o_busy, 0);
    chk("module_select_held", o_module_select, e.mod_sel);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; cfg_wr_valid = 1'b0; cfg_wr_dir = 1'b0; cfg_wr_addr = '0; cfg_wr_sel = '0;
    cmd_valid = 1'b0; cmd_mod_idx = '0; cmd_slot_idx = '0; cmd_count = '0;
    model_clear();
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;

    // no writes yet: identity routes, two miss pulses
    run_cmd(0, 0, 1, 1'b0, '0, 1'b0, 0);

    wr(1'b0, 3, {18{8'h5A}});
    wr(1'b1, 7, {SEL_W{1'b1}});
    run_cmd(3, 7, 4, 1'b0, '0, 1'b0, 0);
    run_cmd(3, 7, 0, 1'b0, '0, 1'b0, 0);

    // write-first on accept, then a rewrite of the active entry during RUN
    run_cmd(3, 7, 5, 1'b1, rand_sel(), 1'b1, 0);
    run_cmd(3, 7, 1, 1'b0, '0, 1'b0, 0);

    for (int k = 0; k < 4; k++) begin
      wr(1'b0, $urandom_range(0, 15), rand_sel());
      wr(1'b1, $urandom_range(0, 15), rand_sel());
      run_cmd($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 20),
              1'b0, '0, 1'b0, 0);
    end
    run_cmd(3, 7, 255, 1'b0, '0, 1'b0, 0);

    // reset during beat 2 aborts; tables then read as unwritten
    run_cmd(3, 7, 6, 1'b0, '0, 1'b0, 3);
    run_cmd(3, 7, 1, 1'b0, '0, 1'b0, 0);

`ifdef BENES_SEQ_PARITY_EN
    wr(1'b0, 5, rand_sel());
    wr(1'b1, 7, rand_sel());
    @(negedge clk);
    dut.u_mod_table.mem[5][0] = ~dut.u_mod_table.mem[5][0];
    mod_ref[5][0] = ~mod_ref[5][0];
    err_model = 1'b1;
    run_cmd(5, 7, 2, 1'b0, '0, 1'b0, 0);
    run_cmd(7, 7, 1, 1'b0, '0, 1'b0, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    chk("cfg_err_cleared", o_cfg_err, 0);
`endif

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
